// File: rtl/sprite_pkg.sv
// sprite_pkg
// Shared types and constants for the sprite write master:
//   sprite_req_t      - one queued sprite update (x, y, sprite number, property bits)
//   SPR_ADDR_*        - register addresses of the display's sprite port
//   sprite_wr_state_t - write master FSM states
package sprite_pkg;

   typedef struct packed {
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] spnum;
      logic [7:0] pbit;
   } sprite_req_t;

   localparam logic [3:0] SPR_ADDR_X  = 4'd0;
   localparam logic [3:0] SPR_ADDR_Y  = 4'd1;
   localparam logic [3:0] SPR_ADDR_SP = 4'd2;
   localparam logic [3:0] SPR_ADDR_PB = 4'd3;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT_VB = 3'd1,
      WR_X    = 3'd2,
      WR_Y    = 3'd3,
      WR_SP   = 3'd4,
      WR_PB   = 3'd5
   } sprite_wr_state_t;

endpackage

// File: rtl/sprite_req_fifo.sv
// sprite_req_fifo
// Synchronous FIFO of sprite_req_t updates. The head entry is presented
// combinationally so the consumer can capture it on the same edge it pops.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset (clears pointers/count)
//   push          - write push_data if not full (ignored when full)
//   push_data     - update to store
//   pop           - remove head if not empty (ignored when empty)
//   head          - current head entry (valid while !empty)
//   full, empty   - occupancy flags
//   count         - occupancy, 0..DEPTH
module sprite_req_fifo
   import sprite_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   push,
   input  sprite_req_t            push_data,
   input  logic                   pop,
   output sprite_req_t            head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   sprite_req_t   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Storage carries no reset: stale entries are unreachable once the
   // pointers and count are cleared.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // DEPTH is a power of two, so the pointers wrap naturally. The count
   // cannot exceed DEPTH because pushes are masked at full.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sprite_write_master.sv
// sprite_write_master
// Avalon-MM write initiator for the display's sprite register port. Queued
// sprite updates are replayed as four ordered byte writes (address 0..3 =
// x, y, sprite number, property bits), each held until waitrequest is low.
// Build option: define VBLANK_SYNC_EN to restrict updates to the vertical
// blanking interval, at most MAX_PER_FRAME updates per vblank start.
// Ports:
//   clk, reset_n       - clock, asynchronous active-low reset
//   req_valid/req_ready- update push handshake (req_ready = !full)
//   req_x/y/spnum/pbit - update fields
//   vga_vs_n           - display vsync, active-low (used only with VBLANK_SYNC_EN)
//   address, writedata, write, chipselect, waitrequest - Avalon-MM initiator
//   busy               - FSM active or updates pending
//   fifo_count         - queued update count
module sprite_write_master
   import sprite_pkg::*;
#(
   parameter int DEPTH         = 4,
   parameter int MAX_PER_FRAME = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [7:0]             req_x,
   input  logic [7:0]             req_y,
   input  logic [7:0]             req_spnum,
   input  logic [7:0]             req_pbit,
   input  logic                   vga_vs_n,
   output logic [3:0]             address,
   output logic [7:0]             writedata,
   output logic                   write,
   output logic                   chipselect,
   input  logic                   waitrequest,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_count
);

   sprite_wr_state_t state;
   sprite_req_t      hold;
   sprite_req_t      fifo_head;
   sprite_req_t      push_data;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_pop;
   logic             gate_open;
   logic             vb_start;
   logic             upd_done;

   assign push_data = '{x: req_x, y: req_y, spnum: req_spnum, pbit: req_pbit};

   sprite_req_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (req_valid),
      .push_data (push_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign req_ready  = !fifo_full;
   assign busy       = (state != IDLE) || !fifo_empty;
   assign chipselect = write;
   assign fifo_pop   = (state == IDLE) && !fifo_empty && gate_open;
   assign upd_done   = (state == WR_PB) && !waitrequest;

`ifdef VBLANK_SYNC_EN
   localparam int BW = $clog2(MAX_PER_FRAME + 1);

   logic          vs_q;
   logic [BW-1:0] budget;

   assign vb_start  = vs_q && !vga_vs_n;
   assign gate_open = (budget != '0);

   // A vblank start reloads the budget even if an update completes on the
   // same edge: the new frame's allowance replaces the old one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vs_q   <= 1'b1;
         budget <= '0;
      end else begin
         vs_q <= vga_vs_n;
         if (vb_start)
            budget <= BW'(MAX_PER_FRAME);
         else if (upd_done && budget != '0)
            budget <= budget - 1'b1;
      end
   end
`else
   localparam int unused_max_per_frame = MAX_PER_FRAME;
   logic unused_vs;

   assign unused_vs = vga_vs_n;
   assign vb_start  = 1'b0;
   assign gate_open = 1'b1;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         hold      <= '0;
         write     <= 1'b0;
         address   <= SPR_ADDR_X;
         writedata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  if (gate_open) begin
                     // Capture the whole update now; later writes read the
                     // holding register so the FIFO can keep filling.
                     hold      <= fifo_head;
                     state     <= WR_X;
                     write     <= 1'b1;
                     address   <= SPR_ADDR_X;
                     writedata <= fifo_head.x;
                  end else if (!vb_start) begin
                     // A vblank start on this edge opens the gate next
                     // cycle; parking in WAIT_VB would miss it.
                     state <= WAIT_VB;
                  end
               end
            end
            WAIT_VB: begin
               if (vb_start) state <= IDLE;
            end
            WR_X: begin
               if (!waitrequest) begin
                  state     <= WR_Y;
                  address   <= SPR_ADDR_Y;
                  writedata <= hold.y;
               end
            end
            WR_Y: begin
               if (!waitrequest) begin
                  state     <= WR_SP;
                  address   <= SPR_ADDR_SP;
                  writedata <= hold.spnum;
               end
            end
            WR_SP: begin
               if (!waitrequest) begin
                  state     <= WR_PB;
                  address   <= SPR_ADDR_PB;
                  writedata <= hold.pbit;
               end
            end
            WR_PB: begin
               if (!waitrequest) begin
                  state <= IDLE;
                  write <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               write <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_write_master.sv
module tb_sprite_write_master;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] req_x, req_y, req_spnum, req_pbit;
   logic       vga_vs_n;
   logic [3:0] address;
   logic [7:0] writedata;
   logic       write;
   logic       chipselect;
   logic       waitrequest;
   logic       busy;
   logic [2:0] fifo_count;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [3:0] a;
      logic [7:0] d;
      int         c;
   } wr_t;
   wr_t wlog[$];

   typedef struct {
      logic [7:0]  x, y, sp, pb;
      logic [31:0] exp_wd;   // expected data for addresses 0..3, MSB first
   } vec_t;
   vec_t vt[4];

   sprite_write_master #(.DEPTH(4), .MAX_PER_FRAME(2)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_x       (req_x),
      .req_y       (req_y),
      .req_spnum   (req_spnum),
      .req_pbit    (req_pbit),
      .vga_vs_n    (vga_vs_n),
      .address     (address),
      .writedata   (writedata),
      .write       (write),
      .chipselect  (chipselect),
      .waitrequest (waitrequest),
      .busy        (busy),
      .fifo_count  (fifo_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Record every accepted Avalon write (write high, no stall).
   always @(negedge clk)
      if (reset_n && write && !waitrequest)
         wlog.push_back('{address, writedata, cyc});

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic push_req(input logic [7:0] x, y, sp, pb);
      req_valid = 1'b1;
      req_x = x; req_y = y; req_spnum = sp; req_pbit = pb;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   // Update k of a sequence with base b carries fields b*16+1 .. b*16+4.
   task automatic push_seq(input int b);
      push_req(8'(b*16+1), 8'(b*16+2), 8'(b*16+3), 8'(b*16+4));
   endtask

   task automatic wait_idle(input int maxc);
      int n = 0;
      @(negedge clk);
      while (busy && n < maxc) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", 32'(busy), 32'd0);
      #1;
   endtask

   // Check logged writes [first, first+4*nupd) against bases b0, b0+1, ...
   task automatic chk_seq(input string nm, input int first, input int nupd, input int b0);
      for (int j = 0; j < 4*nupd; j++) begin
         if (first + j < wlog.size()) begin
            chk({nm, "_addr"}, 32'(wlog[first+j].a), 32'(j % 4));
            chk({nm, "_data"}, 32'(wlog[first+j].d), 32'((b0 + j/4)*16 + j%4 + 1));
         end else begin
            chk({nm, "_missing"}, 32'(first + j), 32'(wlog.size()));
         end
      end
   endtask

   initial begin
      logic [3:0] sa[4];
      logic [7:0] sd[4];
      int         found;
      int         n0;
      logic [2:0] exp_cnt[6];
      logic       exp_rdy[6];

      reset_n = 1'b0; req_valid = 1'b0; req_x = '0; req_y = '0;
      req_spnum = '0; req_pbit = '0; vga_vs_n = 1'b1; waitrequest = 1'b0;

      vt[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 32'h11223344};
      vt[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000};
      vt[2] = '{8'hFF, 8'hFE, 8'h7F, 8'h01, 32'hFFFE7F01};
      vt[3] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 32'hA55AC33C};

      // ---- reset state ----
      repeat (2) @(negedge clk);
      chk("rst_write", 32'(write), 0);
      chk("rst_cs", 32'(chipselect), 0);
      chk("rst_addr", 32'(address), 0);
      chk("rst_wdata", 32'(writedata), 0);
      chk("rst_ready", 32'(req_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_count", 32'(fifo_count), 0);
      reset_n = 1'b1;
      @(posedge clk); #1;

`ifdef VBLANK_SYNC_EN
      // ---- vblank gating: 3 queued, 2 per frame ----
      wlog.delete();
      push_seq(1); push_seq(2); push_seq(3);
      repeat (10) @(posedge clk);
      #1;
      chk("vb_closed_writes", 32'(wlog.size()), 0);
      chk("vb_closed_busy", 32'(busy), 1);
      vga_vs_n = 1'b0;
      @(posedge clk); #1;
      vga_vs_n = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      chk("vb_frame1_writes", 32'(wlog.size()), 8);
      chk("vb_frame1_count", 32'(fifo_count), 1);
      vga_vs_n = 1'b0;
      @(posedge clk); #1;
      vga_vs_n = 1'b1;
      wait_idle(60);
      chk("vb_frame2_writes", 32'(wlog.size()), 12);
      chk_seq("vb_order", 0, 3, 1);
`else
      // ---- single update latency and sequence ----
      push_req(8'h28, 8'h1E, 8'h01, 8'h80);
      @(negedge clk);
      chk("lat_no_write_yet", 32'(write), 0);
      chk("lat_count", 32'(fifo_count), 1);
      sa = '{4'd0, 4'd1, 4'd2, 4'd3};
      sd = '{8'h28, 8'h1E, 8'h01, 8'h80};
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("single_write", 32'(write), 1);
         chk("single_cs", 32'(chipselect), 1);
         chk("single_addr", 32'(address), 32'(sa[k]));
         chk("single_data", 32'(writedata), 32'(sd[k]));
      end
      @(negedge clk);
      chk("single_write_off", 32'(write), 0);
      chk("single_busy_off", 32'(busy), 0);
      @(posedge clk); #1;

      // ---- table-driven back-to-back updates ----
      wlog.delete();
      for (int i = 0; i < 4; i++) push_req(vt[i].x, vt[i].y, vt[i].sp, vt[i].pb);
      wait_idle(100);
      chk("tbl_nwrites", 32'(wlog.size()), 16);
      for (int j = 0; j < 16 && j < wlog.size(); j++) begin
         chk("tbl_addr", 32'(wlog[j].a), 32'(j % 4));
         chk("tbl_data", 32'(wlog[j].d), 32'(vt[j/4].exp_wd[31 - 8*(j%4) -: 8]));
         if (j > 0)
            chk("tbl_spacing", 32'(wlog[j].c - wlog[j-1].c), (j % 4 == 0) ? 32'd2 : 32'd1);
      end

      // ---- waitrequest stall in WR_Y ----
      wlog.delete();
      push_req(8'h28, 8'h1E, 8'h01, 8'h80);
      @(posedge clk); #1;          // WR_X cycle
      @(posedge clk); #1;          // WR_Y cycle 1
      waitrequest = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("stall_write", 32'(write), 1);
         chk("stall_addr", 32'(address), 1);
         chk("stall_data", 32'(writedata), 32'h1E);
         if (k < 3) begin
            @(posedge clk); #1;
            if (k == 2) waitrequest = 1'b0;
         end
      end
      @(negedge clk);
      chk("stall_next_addr", 32'(address), 2);
      chk("stall_next_data", 32'(writedata), 32'h01);
      wait_idle(50);
      chk("stall_nwrites", 32'(wlog.size()), 4);

      // ---- overflow: 1 in flight + 5 pushes into DEPTH=4 ----
      wlog.delete();
      waitrequest = 1'b1;
      exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
      exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         push_seq(i);
         chk("full_count", 32'(fifo_count), 32'(exp_cnt[i]));
         chk("full_ready", 32'(req_ready), 32'(exp_rdy[i]));
      end
      waitrequest = 1'b0;
      wait_idle(200);
      chk("full_nwrites", 32'(wlog.size()), 20);
      chk_seq("full_order", 0, 5, 0);

      // ---- simultaneous push and pop at count 2 ----
      wlog.delete();
      waitrequest = 1'b1;
      push_seq(6); push_seq(7); push_seq(8);
      chk("pp_count_before", 32'(fifo_count), 2);
      waitrequest = 1'b0;
      found = 0;
      for (int n = 0; n < 20 && found == 0; n++) begin
         @(negedge clk);
         if (!write) found = 1;
      end
      chk("pp_idle_found", 32'(found), 1);
      req_valid = 1'b1;
      req_x = 8'h91; req_y = 8'h92; req_spnum = 8'h93; req_pbit = 8'h94;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("pp_count_after", 32'(fifo_count), 2);
      wait_idle(100);
      chk("pp_nwrites", 32'(wlog.size()), 16);
      chk_seq("pp_order", 0, 4, 6);

      // ---- reset mid-burst ----
      push_seq(10); push_seq(11); push_seq(12);
      found = 0;
      for (int n = 0; n < 20 && found == 0; n++) begin
         @(negedge clk);
         if (write && address == 4'd2) found = 1;
      end
      chk("rst_wrsp_found", 32'(found), 1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("midrst_write", 32'(write), 0);
      chk("midrst_cs", 32'(chipselect), 0);
      chk("midrst_count", 32'(fifo_count), 0);
      chk("midrst_addr", 32'(address), 0);
      n0 = wlog.size();
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("postrst_ready", 32'(req_ready), 1);
      chk("postrst_busy", 32'(busy), 0);
      chk("postrst_no_writes", 32'(wlog.size()), 32'(n0));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
